// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings for the register-file controller and its datapath:
// FSM states, instruction op codes, ALU op codes.
package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_MOVI = 2'b00,
        OP_MOV  = 2'b01,
        OP_ADD  = 2'b10,
        OP_AND  = 2'b11
    } op_e;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_AND = 2'b01;

    // MOVI needs no operands, MOV only needs B, ADD/AND need both.
    function automatic state_e first_state(input op_e op);
        case (op)
            OP_MOVI: first_state = S_WRITE;
            OP_MOV:  first_state = S_LOAD_B;
            default: first_state = S_LOAD_A;
        endcase
    endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Request/control bundle between the instruction source (master) and the
// register-file controller (slave).
interface regfile_ctrl_if;
    logic       start;
    logic [1:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       busy;
    logic       done;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       asel;
    logic [1:0] aluop;

    modport master (
        output start, op, rd, rs1, rs2,
        input  busy, done, readnum, writenum, write, vsel,
        input  loada, loadb, loadc, asel, aluop
    );

    modport slave (
        input  start, op, rd, rs1, rs2,
        output busy, done, readnum, writenum, write, vsel,
        output loada, loadb, loadc, asel, aluop
    );
endinterface

// File: rtl/regfile_ctrl.sv
// Sequences register-file reads, ALU execute and write-back for MOVI/MOV/ADD/AND.
// Latency accept->done: MOVI 2, MOV 4, ADD/AND 5 cycles.
// No queueing: start is only honoured in IDLE; requests while busy are dropped.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    regfile_ctrl_if.slave  bus
);

    state_e     r_state;
    state_e     w_next_state;
    op_e        r_op;
    logic [2:0] r_rd;
    logic [2:0] r_rs1;
    logic [2:0] r_rs2;
    logic       r_armed;
    logic       w_accept;

    // Blocks acceptance on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_armed <= 1'b0;
        else        r_armed <= 1'b1;
    end

    assign w_accept = (r_state == S_IDLE) && bus.start && r_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= OP_MOVI;
            r_rd  <= 3'd0;
            r_rs1 <= 3'd0;
            r_rs2 <= 3'd0;
        end else if (w_accept) begin
            r_op  <= op_e'(bus.op);
            r_rd  <= bus.rd;
            r_rs1 <= bus.rs1;
            r_rs2 <= bus.rs2;
        end
    end

    always_comb begin
        w_next_state = r_state;
        bus.busy     = (r_state != S_IDLE);
        bus.done     = 1'b0;
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.write    = 1'b0;
        bus.vsel     = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.asel     = 1'b0;
        bus.aluop    = ALUOP_ADD;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = first_state(op_e'(bus.op));
            end
            S_LOAD_A: begin
                bus.readnum  = r_rs1;
                bus.loada    = 1'b1;
                w_next_state = S_LOAD_B;
            end
            S_LOAD_B: begin
                bus.readnum  = r_rs2;
                bus.loadb    = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                bus.loadc    = 1'b1;
                bus.asel     = (r_op == OP_MOV);
                bus.aluop    = (r_op == OP_AND) ? ALUOP_AND : ALUOP_ADD;
                w_next_state = S_WRITE;
            end
            S_WRITE: begin
                bus.write    = 1'b1;
                bus.writenum = r_rd;
                bus.vsel     = (r_op == OP_MOVI);
                w_next_state = S_DONE;
            end
            S_DONE: begin
                bus.done     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low; one clock.
REQ-003 SHALL have port: start  input  1  request to run one operation; sampled only in IDLE.
REQ-004 SHALL have port: op  input  2  operation: 00 MOVI, 01 MOV, 10 ADD, 11 AND.
REQ-005 SHALL have ports: rd, rs1, rs2  input  3 each  destination and source register numbers.
REQ-006 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-008 SHALL have ports: readnum, writenum  output  3 each  register file read and write selects.
REQ-009 SHALL have port: write  output  1  register file write enable.
REQ-010 SHALL have port: vsel  output  1  write-data select: 1 = immediate path, 0 = result register C.
REQ-011 SHALL have ports: loada, loadb, loadc  output  1 each  operand and result register load enables.
REQ-012 SHALL have ports: asel  output  1  forces ALU input A to zero; aluop  output  2  00 ADD, 01 AND.

Function
REQ-013 SHALL use states IDLE, LOAD_A, LOAD_B, EXEC, WRITE and DONE.
REQ-014 SHALL, in IDLE with start=1, latch op, rd, rs1 and rs2 into internal registers.
REQ-015 SHALL run all later states from the latched fields; input changes after acceptance have no effect.
REQ-016 SHALL sequence MOVI as IDLE->WRITE->DONE, with vsel=1 in WRITE.
REQ-017 SHALL sequence MOV as IDLE->LOAD_B->EXEC->WRITE->DONE, with asel=1 and aluop=00 in EXEC.
REQ-018 SHALL sequence ADD and AND as IDLE->LOAD_A->LOAD_B->EXEC->WRITE->DONE, with aluop 00 or 01 in EXEC.
REQ-019 SHALL drive readnum=rs1 and loada=1 in LOAD_A only.
REQ-020 SHALL drive readnum=rs2 and loadb=1 in LOAD_B only.
REQ-021 SHALL drive loadc=1 in EXEC only.
REQ-022 SHALL drive write=1 and writenum=rd in WRITE only; vsel=0 in WRITE except for MOVI.
REQ-023 SHALL keep every other output 0 when not asserted by the current state, so outputs are decoded from state and latched fields only.
REQ-024 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-025 SHALL give latency from the accepting edge to the done cycle of 2 cycles for MOVI, 4 for MOV, and 5 for ADD/AND.
REQ-026 SHALL ignore start while busy; no queueing.
REQ-027 SHALL accept a new start in the cycle immediately after DONE, since that cycle is IDLE.
REQ-028 SHALL allow rd equal to rs1 and/or rs2; sources are read before the write, so the old values are used.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state IDLE and all outputs and latched fields to 0, regardless of clk.
REQ-030 SHALL, on reset during an operation, abandon it with no write and no done pulse.
REQ-031 SHALL ignore start on the first rising edge after rst_n deasserts only if rst_n rose less than one cycle before that edge; otherwise it accepts normally.

Structure
REQ-032 SHALL take the state encoding, the op codes (MOVI/MOV/ADD/AND) and the aluop codes from a shared package used by the datapath.
REQ-033 SHALL be a single module with no sub-modules; the state register and the field latches are internal always blocks.

Verification
REQ-034 SHALL cover: reset, then start op=00 rd=3 -> write=1 and writenum=3 and vsel=1 on cycle 1, done on cycle 2, then busy=0.
REQ-035 SHALL cover: op=10 rd=2 rs1=0 rs2=1 -> in order, readnum 0 with loada, readnum 1 with loadb, loadc with aluop=00, write to 2, done at cycle 5.
REQ-036 SHALL cover: op=01 rd=7 rs2=5 -> no loada; loadb with readnum 5; asel=1 in EXEC; write to 7; done at cycle 4.
REQ-037 SHALL cover: start held high with changing rd during an AND -> second start ignored, original rd written, new op accepted the cycle after done.
REQ-038 SHALL cover: rst_n pulled low in EXEC of an ADD -> all outputs 0 at once, no write, no done, busy=0.
REQ-039 SHALL cover: op=11 rd=rs1=rs2=4 -> reads of 4 precede the write to 4, aluop=01, done at cycle 5.
